johnson_phase_monitor: RTL and testbench

- Downstream consumer of the 4-bit Johnson counter.
- Samples the counter code every clock, decodes it to a binary phase and a one-hot phase, and checks that each code is legal and is the exact successor of the previous one.
- Runs a lock FSM, flags illegal or out-of-sequence codes, and counts full 2*WIDTH-phase revolutions for downstream sequencing and diagnostics logic.

---
 rtl/johnson_pkg.sv | 28 ++
 rtl/johnson_decode.sv | 30 +++
 rtl/johnson_phase_monitor.sv | 132 +++++++++++++
 tb/tb_johnson_phase_monitor.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/johnson_pkg.sv
// Shared types and helpers for the Johnson-code phase monitor.
// Holds the lock FSM encoding and the phase-to-code re-encoder.
package johnson_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACQ  = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  function automatic int ph_w(input int width);
    return $clog2(2 * width);
  endfunction

  // Phases 0..width fill ones from the LSB; later phases keep ones only in the top bits.
  function automatic logic [31:0] johnson_code(input int phase, input int width);
    logic [31:0] code;
    code = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) begin
        if (phase <= width) code[i] = (i < phase);
        else                code[i] = (i >= phase - width);
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/johnson_decode.sv
// Combinational decode of one Johnson code into phase index, legality and one-hot.
// Legality is proven by re-encoding the decoded phase and comparing to the input.
module johnson_decode
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PH_W  = ph_w(WIDTH)
) (
  input  logic [WIDTH-1:0]   i_code,
  output logic [PH_W-1:0]    o_phase,
  output logic               o_legal,
  output logic [2*WIDTH-1:0] o_onehot
);

  int w_pop;
  int w_ph;

  always_comb begin
    w_pop = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (i_code[i]) w_pop++;
    end
    w_ph     = i_code[WIDTH-1] ? (2 * WIDTH - w_pop) : w_pop;
    o_phase  = PH_W'(w_ph);
    o_legal  = (WIDTH'(johnson_code(w_ph, WIDTH)) == i_code);
    o_onehot = '0;
    if (o_legal) o_onehot[o_phase] = 1'b1;
  end

endmodule

// File: rtl/johnson_phase_monitor.sv
// Monitors a Johnson counter stream: decodes phase, checks successor order,
// runs a lock FSM and counts full revolutions. All outputs registered.
module johnson_phase_monitor
  import johnson_pkg::*;
#(
  parameter  int WIDTH       = 4,
  parameter  int LOCK_THRESH = 3,
  parameter  int WRAP_W      = 8,
  localparam int PH_W        = ph_w(WIDTH)
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic [WIDTH-1:0]   Count_in,
  input  logic               Clear,
  output logic [PH_W-1:0]    Phase_out,
  output logic [2*WIDTH-1:0] Phase_onehot,
  output logic               Phase_valid,
  output logic               Locked,
  output logic               Err_illegal,
  output logic               Err_seq,
  output logic               Err_sticky,
  output logic               Wrap_pulse,
  output logic [WRAP_W-1:0]  Wrap_count,
  output state_t             Dbg_state
);

  localparam int              GC_W    = $clog2(LOCK_THRESH + 1);
  localparam logic [PH_W-1:0] LAST_PH = PH_W'(2 * WIDTH - 1);

  state_t             r_state, w_state_nxt;
  logic [GC_W-1:0]    r_good_cnt, w_good_nxt;
  logic [PH_W-1:0]    r_prev_phase, r_phase_out;
  logic [2*WIDTH-1:0] r_onehot;
  logic               r_valid, r_locked, r_err_ill, r_err_seq, r_sticky, r_wrap;
  logic [WRAP_W-1:0]  r_wrap_count;

  logic [PH_W-1:0]    w_phase, w_exp_phase;
  logic [2*WIDTH-1:0] w_onehot;
  logic               w_legal, w_ref, w_succ, w_seq_err, w_wrap;

  johnson_decode #(.WIDTH(WIDTH), .PH_W(PH_W)) u_decode (
    .i_code   (Count_in),
    .o_phase  (w_phase),
    .o_legal  (w_legal),
    .o_onehot (w_onehot)
  );

  // A valid reference phase exists exactly when the FSM has left S_IDLE.
  assign w_ref       = (r_state != S_IDLE);
  assign w_exp_phase = (r_prev_phase == LAST_PH) ? '0 : r_prev_phase + PH_W'(1);
  assign w_succ      = w_ref && w_legal && (w_phase == w_exp_phase);
  assign w_seq_err   = w_ref && w_legal && (w_phase != w_exp_phase);
  assign w_wrap      = (r_state == S_LOCK) && w_succ && (r_prev_phase == LAST_PH);

  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    if (!w_legal) begin
      w_state_nxt = S_IDLE;
      w_good_nxt  = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_nxt = S_ACQ;
          w_good_nxt  = '0;
        end
        S_ACQ: begin
          if (w_succ) begin
            w_good_nxt = r_good_cnt + GC_W'(1);
            if (int'(w_good_nxt) >= LOCK_THRESH) w_state_nxt = S_LOCK;
          end else begin
            w_good_nxt = '0;
          end
        end
        S_LOCK: begin
          if (!w_succ) begin
            w_state_nxt = S_ACQ;
            w_good_nxt  = '0;
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_state      <= S_IDLE;
      r_good_cnt   <= '0;
      r_prev_phase <= '0;
      r_phase_out  <= '0;
      r_onehot     <= '0;
      r_valid      <= 1'b0;
      r_locked     <= 1'b0;
      r_err_ill    <= 1'b0;
      r_err_seq    <= 1'b0;
      r_sticky     <= 1'b0;
      r_wrap       <= 1'b0;
      r_wrap_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_good_cnt <= w_good_nxt;
      r_locked   <= (w_state_nxt == S_LOCK);
      r_valid    <= w_legal;
      r_onehot   <= w_onehot;
      r_err_ill  <= !w_legal;
      r_err_seq  <= w_seq_err;
      r_wrap     <= w_wrap;
      if (w_legal) begin
        r_phase_out  <= w_phase;
        r_prev_phase <= w_phase;
      end
      // A new error outranks a simultaneous Clear.
      if (!w_legal || w_seq_err) r_sticky <= 1'b1;
      else if (Clear)            r_sticky <= 1'b0;
      if (Clear)                                   r_wrap_count <= w_wrap ? WRAP_W'(1) : '0;
      else if (w_wrap && (r_wrap_count != '1))     r_wrap_count <= r_wrap_count + WRAP_W'(1);
    end
  end

  assign Phase_out    = r_phase_out;
  assign Phase_onehot = r_onehot;
  assign Phase_valid  = r_valid;
  assign Locked       = r_locked;
  assign Err_illegal  = r_err_ill;
  assign Err_seq      = r_err_seq;
  assign Err_sticky   = r_sticky;
  assign Wrap_pulse   = r_wrap;
  assign Wrap_count   = r_wrap_count;
  assign Dbg_state    = r_state;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Self-checking bench for johnson_phase_monitor (WIDTH=4), with a second
// instance at WRAP_W=2 sharing the stimulus to exercise counter saturation.
module tb_johnson_phase_monitor;
  import johnson_pkg::*;

  localparam int W           = 29;
  localparam int LOCK_THRESH = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       Reset;
  logic       Clear;
  logic [3:0] Count_in;

  logic [2:0] ph_a, ph_b;
  logic [7:0] oh_a, oh_b;
  logic       val_a, val_b, lck_a, lck_b, eill_a, eill_b, eseq_a, eseq_b;
  logic       stk_a, stk_b, wrp_a, wrp_b;
  logic [7:0] wc_a;
  logic [1:0] wc_b;
  state_t     st_a, st_b;

  johnson_phase_monitor #(.WIDTH(4), .LOCK_THRESH(LOCK_THRESH), .WRAP_W(8)) dut_a (
    .clk(clk), .Reset(Reset), .Count_in(Count_in), .Clear(Clear),
    .Phase_out(ph_a), .Phase_onehot(oh_a), .Phase_valid(val_a), .Locked(lck_a),
    .Err_illegal(eill_a), .Err_seq(eseq_a), .Err_sticky(stk_a), .Wrap_pulse(wrp_a),
    .Wrap_count(wc_a), .Dbg_state(st_a)
  );

  johnson_phase_monitor #(.WIDTH(4), .LOCK_THRESH(LOCK_THRESH), .WRAP_W(2)) dut_b (
    .clk(clk), .Reset(Reset), .Count_in(Count_in), .Clear(Clear),
    .Phase_out(ph_b), .Phase_onehot(oh_b), .Phase_valid(val_b), .Locked(lck_b),
    .Err_illegal(eill_b), .Err_seq(eseq_b), .Err_sticky(stk_b), .Wrap_pulse(wrp_b),
    .Wrap_count(wc_b), .Dbg_state(st_b)
  );

  // ---------------- reference model ----------------
  logic [3:0] codes [8];
  int         m_state, m_good, m_prev;
  logic [2:0] m_ph;
  logic [7:0] m_oh, m_w8;
  logic [1:0] m_w2;
  logic       m_valid, m_locked, m_eill, m_eseq, m_sticky, m_wrap;

  logic [W-1:0] exp_q [$];
  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_step(input logic [3:0] c, input logic clr, input logic rst);
    int  ph;
    bit  legal;
    legal = 1'b0;
    ph    = 0;
    for (int k = 0; k < 8; k++) if (codes[k] == c) begin legal = 1'b1; ph = k; end
    if (!rst) begin
      m_state = 0; m_good = 0; m_prev = 0; m_ph = '0; m_oh = '0;
      m_valid = 0; m_locked = 0; m_eill = 0; m_eseq = 0; m_sticky = 0;
      m_wrap = 0; m_w8 = '0; m_w2 = '0;
    end else begin
      m_wrap = 0; m_eill = 0; m_eseq = 0;
      if (!legal) begin
        m_eill = 1; m_valid = 0; m_oh = '0; m_state = 0; m_good = 0;
      end else begin
        m_valid = 1;
        m_oh    = 8'(1 << ph);
        m_ph    = 3'(ph);
        if (m_state == 0) begin
          m_state = 1; m_good = 0;
        end else if (ph == (m_prev + 1) % 8) begin
          if (m_state == 2) begin
            if (m_prev == 7) m_wrap = 1;
          end else begin
            m_good++;
            if (m_good >= LOCK_THRESH) m_state = 2;
          end
        end else begin
          m_eseq = 1; m_good = 0; m_state = 1;
        end
        m_prev = ph;
      end
      m_locked = (m_state == 2);
      if (m_eill || m_eseq) m_sticky = 1;
      else if (clr)         m_sticky = 0;
      if (clr) begin
        m_w8 = m_wrap ? 8'd1 : 8'd0;
        m_w2 = m_wrap ? 2'd1 : 2'd0;
      end else if (m_wrap) begin
        if (m_w8 != 8'hff) m_w8 = m_w8 + 8'd1;
        if (m_w2 != 2'd3)  m_w2 = m_w2 + 2'd1;
      end
    end
    exp_q.push_back({2'(m_state), m_w2, m_w8, m_wrap, m_sticky, m_eseq, m_eill,
                     m_locked, m_valid, m_oh, m_ph});
  endtask

  task automatic compare_out();
    logic [W-1:0] e;
    e = exp_q.pop_front();
    check("phase_out",   ph_a,   e[2:0]);
    check("onehot",      oh_a,   e[10:3]);
    check("phase_valid", val_a,  e[11]);
    check("locked",      lck_a,  e[12]);
    check("err_illegal", eill_a, e[13]);
    check("err_seq",     eseq_a, e[14]);
    check("err_sticky",  stk_a,  e[15]);
    check("wrap_pulse",  wrp_a,  e[16]);
    check("wrap_count8", wc_a,   e[24:17]);
    check("wrap_count2", wc_b,   e[26:25]);
    check("fsm_state",   st_a,   e[28:27]);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic [3:0] c, input logic clr = 1'b0, input logic rst = 1'b1);
    @(negedge clk);
    Count_in = c;
    Clear    = clr;
    Reset    = rst;
    model_step(c, clr, rst);
    @(posedge clk);
    #1;
    cyc++;
    compare_out();
  endtask

  task automatic run(input int start, input int n);
    for (int i = 0; i < n; i++) step(codes[(start + i) % 8]);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int cur;
    int r;
    logic [3:0] c;
    codes = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    Reset = 1'b0; Clear = 1'b0; Count_in = 4'b0000;

    step(4'b0000, 1'b0, 1'b0);
    step(4'b0000, 1'b0, 1'b0);
    run(0, 4);                       // acquire and lock
    run(4, 13);                      // two revolutions with wraps
    step(4'b0101);                   // illegal code
    run(2, 4);                       // relock
    run(6, 5);                       // locked at 0011
    step(4'b1111);                   // skipped phase
    run(5, 3);                       // relock
    run(0, 40);                      // five wraps, narrow counter saturates
    step(4'b0000, 1'b1);             // clear on a wrap cycle
    step(4'b0001);
    step(4'b0001, 1'b1);             // held code with clear
    run(2, 5);
    step(codes[7], 1'b0, 1'b0);      // one-cycle reset mid-stream
    run(0, 6);

    cur = 6;
    for (int i = 0; i < 80; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      c = 4'($urandom_range(0, 15));
      else if (r == 1) c = codes[cur];
      else begin
        cur = (cur + 1) % 8;
        c   = codes[cur];
      end
      step(c, ($urandom_range(0, 15) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
